// File: rtl/regfile_pkg.sv
// Shared types and default widths for the ID-stage register file,
// its scoreboard, the decoder and the forwarding unit.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback (set wins on a
// same-address collision), with the two read-port lookups.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              busy1,
    output logic              busy2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] busy_next;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (en && set_en)
            set_vec[set_addr] = 1'b1;
        if (ZERO_REG != 0)
            set_vec[0] = 1'b0;
        if (en && clr_en)
            clr_vec[clr_addr] = 1'b1;
        // A newer issue supersedes the write completing in the same cycle.
        busy_next = (busy & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_next;
    end

    // A completing write un-stalls its consumer in the same cycle, matching bypass.
    assign busy1 = en && busy[rd1_addr] && !(clr_en && (clr_addr == rd1_addr))
                   && !((ZERO_REG != 0) && (rd1_addr == '0));
    assign busy2 = en && busy[rd2_addr] && !(clr_en && (clr_addr == rd2_addr))
                   && !((ZERO_REG != 0) && (rd2_addr == '0));

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with optional zero register, write-to-read
// bypass, busy scoreboard and a post-reset clear sweep.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [ADDR_W-1:0] r2_addr,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] din,
    input  logic              write_en,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              busy1,
    output logic              busy2,
    output logic              init_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic              run;
    logic              wr_ok;

    assign run       = (state == RUN);
    assign init_done = run;
    assign wr_ok     = run && write_en && !((ZERO_REG != 0) && (w_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == INIT)
                cnt <= cnt + 1'b1;
        end
    end

    // Sweep ends after the last register is cleared; cnt never needs to wrap.
    always_comb begin
        state_next = state;
        if (state == INIT && (&cnt))
            state_next = RUN;
    end

    always_ff @(posedge clk) begin
        if (!run)
            mem[cnt] <= '0;
        else if (wr_ok && rst_n)
            mem[w_addr] <= din;
    end

    always_comb begin
        r1 = mem[r1_addr];
        if ((BYPASS != 0) && wr_ok && (w_addr == r1_addr))
            r1 = din;
        if (!run || ((ZERO_REG != 0) && (r1_addr == '0)))
            r1 = '0;
    end

    always_comb begin
        r2 = mem[r2_addr];
        if ((BYPASS != 0) && wr_ok && (w_addr == r2_addr))
            r2 = din;
        if (!run || ((ZERO_REG != 0) && (r2_addr == '0)))
            r2 = '0;
    end

    regfile_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (run),
        .set_en  (issue_valid),
        .set_addr(issue_rd),
        .clr_en  (write_en),
        .clr_addr(w_addr),
        .rd1_addr(r1_addr),
        .rd2_addr(r2_addr),
        .busy1   (busy1),
        .busy2   (busy2)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios then random traffic, checked
// against an architectural model of the register file and scoreboard.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  r1_addr, r2_addr, w_addr, issue_rd;
    logic [31:0] din;
    logic        write_en, issue_valid;
    logic [31:0] r1, r2, nb_r1, nb_r2;
    logic        busy1, busy2, init_done, nb_busy1, nb_busy2, nb_init_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model: contents, pending-write flags, sweep progress.
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    bit          m_run;
    int          m_since;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .r1_addr(r1_addr), .r2_addr(r2_addr),
        .r1(r1), .r2(r2), .w_addr(w_addr), .din(din), .write_en(write_en),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy1(busy1), .busy2(busy2), .init_done(init_done)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .r1_addr(r1_addr), .r2_addr(r2_addr),
        .r1(nb_r1), .r2(nb_r2), .w_addr(w_addr), .din(din), .write_en(write_en),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy1(nb_busy1), .busy2(nb_busy2), .init_done(nb_init_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (!m_run || a == 5'd0) return 32'd0;
        if (byp && write_en && w_addr == a && w_addr != 5'd0) return din;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!m_run || a == 5'd0) return 1'b0;
        return m_busy[a] && !(write_en && w_addr == a);
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_run   = 0;
            m_since = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else if (!m_run) begin
            m_since++;
            if (m_since == 32) begin
                m_run = 1;
                foreach (m_mem[i]) m_mem[i] = 32'd0;
            end
        end else begin
            if (write_en) begin
                if (w_addr != 5'd0) m_mem[w_addr] = din;
                m_busy[w_addr] = 0;
            end
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1;
        end
    endtask

    task automatic step();
        #1;
        check("r1", r1, exp_rd(r1_addr, 1));
        check("r2", r2, exp_rd(r2_addr, 1));
        check("busy1", {31'd0, busy1}, {31'd0, exp_busy(r1_addr)});
        check("busy2", {31'd0, busy2}, {31'd0, exp_busy(r2_addr)});
        check("init_done", {31'd0, init_done}, {31'd0, m_run});
        check("nb_r1", nb_r1, exp_rd(r1_addr, 0));
        check("nb_r2", nb_r2, exp_rd(r2_addr, 0));
        check("nb_busy1", {31'd0, nb_busy1}, {31'd0, exp_busy(r1_addr)});
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        write_en    = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic sweep_and_measure(input string tag, input bit poke);
        int n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            idle();
            if (poke && n == 5) begin
                write_en = 1'b1; w_addr = 5'd3; din = 32'h55; r1_addr = 5'd3;
            end
            step();
            n++;
        end
        idle();
        check(tag, n, 32);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            r1_addr = 5'(2 * i);
            r2_addr = 5'(2 * i + 1);
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; r1_addr = '0; r2_addr = '0; w_addr = '0; din = '0;
        issue_rd = '0; idle();
        @(posedge clk);
        model_edge();
        @(negedge clk);

        // Reset held, then sweep length and an ignored write during INIT.
        step();
        step();
        rst_n = 1'b1;
        sweep_and_measure("sweep_len", 1);
        read_all();

        // Bypass vs. storage.
        w_addr = 5'd5; din = 32'hDEADBEEF; write_en = 1'b1; r1_addr = 5'd5; r2_addr = 5'd1;
        #1;
        check("bypass_r1", r1, 32'hDEADBEEF);
        check("nobypass_r1", nb_r1, 32'd0);
        step();
        idle();
        #1;
        check("stored_r1", r1, 32'hDEADBEEF);
        step();

        // Zero register ignores writes and issues.
        w_addr = 5'd0; din = 32'h1234; write_en = 1'b1; r1_addr = 5'd0; r2_addr = 5'd0;
        #1;
        check("zero_r1_wr", r1, 32'd0);
        step();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd0;
        step();
        idle();
        #1;
        check("zero_busy1", {31'd0, busy1}, 32'd0);
        step();

        // Scoreboard set, then clear by writeback with bypass.
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        idle();
        r2_addr = 5'd7;
        #1;
        check("sb_busy2_set", {31'd0, busy2}, 32'd1);
        step();
        write_en = 1'b1; w_addr = 5'd7; din = 32'd9;
        #1;
        check("sb_busy2_clr", {31'd0, busy2}, 32'd0);
        check("sb_r2_byp", r2, 32'd9);
        step();
        idle();
        #1;
        check("sb_busy2_after", {31'd0, busy2}, 32'd0);
        step();

        // Set/clear collision on one address, then on different addresses.
        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        issue_valid = 1'b1; issue_rd = 5'd4; write_en = 1'b1; w_addr = 5'd4; din = 32'h44;
        step();
        idle();
        r1_addr = 5'd4;
        #1;
        check("coll_same", {31'd0, busy1}, 32'd1);
        step();
        issue_valid = 1'b1; issue_rd = 5'd6; write_en = 1'b1; w_addr = 5'd4; din = 32'h66;
        step();
        idle();
        r1_addr = 5'd6; r2_addr = 5'd4;
        #1;
        check("coll_diff_set", {31'd0, busy1}, 32'd1);
        check("coll_diff_clr", {31'd0, busy2}, 32'd0);
        step();

        // Random traffic concentrated on a few registers to provoke collisions.
        for (int k = 0; k < 400; k++) begin
            rst_n       = ($urandom_range(0, 149) != 0);
            r1_addr     = 5'($urandom_range(0, 7));
            r2_addr     = 5'($urandom_range(0, 31));
            w_addr      = 5'($urandom_range(0, 7));
            issue_rd    = 5'($urandom_range(0, 7));
            din         = $urandom;
            write_en    = rst_n && ($urandom_range(0, 1) == 1);
            issue_valid = rst_n && ($urandom_range(0, 1) == 1);
            step();
        end

        // Reset in the middle of the sweep restarts it from the beginning.
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sweep_and_measure("midsweep_len", 0);
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 2-read/1-write register file.
- Adds configurable data width and depth, an optional hardwired zero register, and write-to-read bypass.
- Adds a per-register busy scoreboard for load-use / multi-cycle hazard detection.
- Adds a sequential post-reset clear sweep that replaces simulation-only initialisation, so the block clears correctly on FPGA.
- Sits in the ID stage: read ports feed operand muxes, the write port is driven from WB, the issue port is driven by the decoder.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never marked busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- r1_addr  in  ADDR_W  read port 1 address
- r2_addr  in  ADDR_W  read port 2 address
- r1  out  DATA_W  read port 1 data, combinational
- r2  out  DATA_W  read port 2 data, combinational
- w_addr  in  ADDR_W  write address
- din  in  DATA_W  write data
- write_en  in  1  write strobe; also clears busy[w_addr]
- issue_valid  in  1  marks issue_rd as pending write
- issue_rd  in  ADDR_W  destination being issued
- busy1  out  1  r1_addr has a pending write, combinational
- busy2  out  1  r2_addr has a pending write, combinational
- init_done  out  1  high once the clear sweep has finished

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset is sampled only on a rising edge of clk while rst_n==0. Any cycle, including mid-sweep, it:
  - forces the FSM to INIT and the sweep counter to 0;
  - clears all busy bits;
  - drives init_done=0 from the next cycle.
- FSM INIT:
  - Each cycle writes 0 to regfile[cnt], then cnt++.
  - On cnt==DEPTH-1, moves to RUN next cycle.
  - Sweep takes exactly DEPTH cycles after rst_n is released.
  - During INIT: write_en and issue_valid are ignored; r1/r2 read 0; busy1/busy2 read 0.
- FSM RUN:
  - init_done=1; stays in RUN until reset.
- Write (RUN): at the rising edge with write_en=1, regfile[w_addr] <= din, except w_addr==0 when ZERO_REG=1.
- Read:
  - rN = 0 if ZERO_REG and rN_addr==0.
  - Otherwise rN = din if BYPASS and write_en and w_addr==rN_addr (and the write is legal).
  - Otherwise rN = regfile[rN_addr].
  - Both ports may read the same address.
- Scoreboard (RUN), busy[DEPTH] register:
  - Set on issue_valid for issue_rd; clear on write_en for w_addr.
  - Same address set and clear in one cycle: set wins, because a newer issue supersedes the completing write.
  - Different addresses: both take effect.
  - Register 0 is never set when ZERO_REG=1.
  - Write to a non-busy register: busy stays 0, no error.
- busyN = busy[rN_addr] & ~(write_en & w_addr==rN_addr). A completing write therefore un-stalls in the same cycle, consistent with bypass. busyN is forced 0 for register 0 when ZERO_REG=1.
- Widths: no arithmetic on data; cnt is ADDR_W bits plus a terminal-compare. No wrap is needed because the FSM exits at DEPTH-1.
- Reset values: r1=r2=0 (INIT reads), busy1=busy2=0, init_done=0.

Decomposition:
- Shared package regfile_pkg holds:
  - the FSM state encoding (INIT, RUN);
  - the default DATA_W/ADDR_W constants, also used by the decoder and forwarding unit.
- One natural sub-module, regfile_scoreboard: the busy-bit vector with set/clear priority and the busyN lookup.
- Storage, sweep FSM and read muxes stay in the top.

Test Plan:
- Reset/sweep: hold rst_n=0 for 2 cycles, release -> init_done=0 for exactly 32 cycles, then 1. Reads of every address = 0. A write of 0x55 to reg 3 during INIT is ignored, so reg 3 reads 0.
- Write/read/bypass: write din=0xDEADBEEF to w_addr=5 with r1_addr=5 in the same cycle -> r1=0xDEADBEEF combinationally (BYPASS=1). The next cycle r1 still reads 0xDEADBEEF from storage. With BYPASS=0, r1 reads the old value 0 during the write cycle.
- Zero register: write 0x1234 to w_addr=0 with r1_addr=r2_addr=0 -> r1=r2=0 in that cycle and after. issue_valid with issue_rd=0 -> busy1 stays 0.
- Scoreboard: issue rd=7; the next cycle r2_addr=7 -> busy2=1. Then write_en with w_addr=7, din=9 -> busy2=0 and r2=9 in the same cycle; busy[7]=0 afterwards.
- Set/clear collision: busy[4]=1, then in one cycle issue_rd=4 and write w_addr=4 -> busy[4] remains 1 next cycle. Simultaneous issue rd=6 with write w_addr=4 -> busy[6]=1, busy[4]=0.
- Mid-sweep reset: assert rst_n=0 at sweep cycle 10 for 1 cycle -> the sweep restarts. init_done rises 32 cycles after release, not 22, and all registers read 0.
